// File: rtl/tlul_axi_bridge_if.sv
// TL-UL A/D channel plus AXI4-Lite AW/W/B/AR/R signal bundle for tlul_axi_bridge.
// slave  : the bridge's view (TL-UL device, AXI4-Lite master).
// master : the surrounding environment (TL-UL host, AXI4-Lite subordinate).
interface tlul_axi_bridge_if #(
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32,
   parameter int unsigned SrcW = 8
) ();
   // TL-UL A channel
   logic            tl_a_valid;
   logic            tl_a_ready;
   logic [2:0]      tl_a_opcode;
   logic [AW-1:0]   tl_a_address;
   logic [DW-1:0]   tl_a_data;
   logic [DW/8-1:0] tl_a_mask;
   logic [SrcW-1:0] tl_a_source;
   logic [1:0]      tl_a_size;
   // TL-UL D channel
   logic            tl_d_valid;
   logic            tl_d_ready;
   logic [2:0]      tl_d_opcode;
   logic [DW-1:0]   tl_d_data;
   logic [SrcW-1:0] tl_d_source;
   logic [1:0]      tl_d_size;
   logic            tl_d_error;
   // AXI4-Lite
   logic            awvalid;
   logic            awready;
   logic [AW-1:0]   awaddr;
   logic            wvalid;
   logic            wready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            bvalid;
   logic            bready;
   logic [1:0]      bresp;
   logic            arvalid;
   logic            arready;
   logic [AW-1:0]   araddr;
   logic            rvalid;
   logic            rready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;

   modport slave (
      input  tl_a_valid, tl_a_opcode, tl_a_address, tl_a_data, tl_a_mask, tl_a_source,
             tl_a_size, tl_d_ready, awready, wready, bvalid, bresp, arready, rvalid, rdata,
             rresp,
      output tl_a_ready, tl_d_valid, tl_d_opcode, tl_d_data, tl_d_source, tl_d_size,
             tl_d_error, awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr,
             rready
   );

   modport master (
      output tl_a_valid, tl_a_opcode, tl_a_address, tl_a_data, tl_a_mask, tl_a_source,
             tl_a_size, tl_d_ready, awready, wready, bvalid, bresp, arready, rvalid, rdata,
             rresp,
      input  tl_a_ready, tl_d_valid, tl_d_opcode, tl_d_data, tl_d_source, tl_d_size,
             tl_d_error, awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr,
             rready
   );
endinterface

// File: rtl/tlul_axi_bridge.sv
// TL-UL device-side to AXI4-Lite master bridge with an in-order response tracker.
// Optional macro TLUL_AXI_BRIDGE_RSP_REG_EN: registers the D channel through a 2-entry
// skid buffer (+1 cycle response latency); otherwise D is combinational from the head.
module tlul_axi_bridge #(
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned SrcW           = 8,
   parameter int unsigned MaxOutstanding = 4
) (
   input logic              clk,
   input logic              rst,
   tlul_axi_bridge_if.slave bus
);

   localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned StrbW = DW / 8;
   localparam logic [1:0]  MaxSize = 2'($clog2(StrbW));
   localparam logic [PtrW:0] CntMax = (PtrW + 1)'(MaxOutstanding);

   localparam logic [2:0] OpPutFull     = 3'd0;
   localparam logic [2:0] OpPutPartial  = 3'd1;
   localparam logic [2:0] OpGet         = 3'd4;
   localparam logic [2:0] OpAccessAck   = 3'd0;
   localparam logic [2:0] OpAccessAckDt = 3'd1;

   // ---------------------------------------------------------------- A channel decode
   logic       a_ready, a_fire, a_is_write, a_is_read, a_err;
   logic [2:0] align_mask;

   // Low-address bits that must be zero for the requested size
   always_comb begin
      unique case (bus.tl_a_size)
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
   end

   assign a_is_write = (bus.tl_a_opcode == OpPutFull) || (bus.tl_a_opcode == OpPutPartial);
   assign a_is_read  = (bus.tl_a_opcode == OpGet);
   assign a_err      = !(a_is_write || a_is_read) || (bus.tl_a_size > MaxSize) ||
                       (|(bus.tl_a_address[2:0] & align_mask));

   logic [PtrW:0] count_q;
   logic          awvalid_q, wvalid_q, arvalid_q;

   // Only one AXI request is ever pending; a new A beat waits until it has fully issued.
   assign a_ready = !rst && (count_q < CntMax) && !awvalid_q && !wvalid_q && !arvalid_q;
   assign a_fire  = bus.tl_a_valid && a_ready;
   assign bus.tl_a_ready = a_ready;

   // ---------------------------------------------------------------- AXI request path
   logic [AW-1:0]    awaddr_q, araddr_q;
   logic [DW-1:0]    wdata_q;
   logic [StrbW-1:0] wstrb_q;

   // Issue AW/W or AR the cycle after acceptance; each channel drops on its own handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         araddr_q  <= '0;
      end else begin
         if (awvalid_q && bus.awready) awvalid_q <= 1'b0;
         if (wvalid_q && bus.wready)   wvalid_q  <= 1'b0;
         if (arvalid_q && bus.arready) arvalid_q <= 1'b0;
         if (a_fire && !a_err && a_is_write) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= bus.tl_a_address;
            wdata_q   <= bus.tl_a_data;
            wstrb_q   <= bus.tl_a_mask;
         end
         if (a_fire && !a_err && a_is_read) begin
            arvalid_q <= 1'b1;
            araddr_q  <= bus.tl_a_address;
         end
      end
   end

   assign bus.awvalid = awvalid_q;
   assign bus.awaddr  = awaddr_q;
   assign bus.wvalid  = wvalid_q;
   assign bus.wdata   = wdata_q;
   assign bus.wstrb   = wstrb_q;
   assign bus.arvalid = arvalid_q;
   assign bus.araddr  = araddr_q;

   // ---------------------------------------------------------------- in-order tracker
   logic [SrcW-1:0] src_mem  [MaxOutstanding];
   logic [1:0]      size_mem [MaxOutstanding];
   logic            read_mem [MaxOutstanding];
   logic            err_mem  [MaxOutstanding];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic            pop;

   // Pointers and occupancy; wrap is implicit since depth is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (a_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({a_fire, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry payload storage; contents are don't-care while the slot is free
   always_ff @(posedge clk) begin
      if (a_fire) begin
         src_mem[wr_ptr_q]  <= bus.tl_a_source;
         size_mem[wr_ptr_q] <= bus.tl_a_size;
         read_mem[wr_ptr_q] <= a_is_read;
         err_mem[wr_ptr_q]  <= a_err;
      end
   end

   // ---------------------------------------------------------------- response merge
   logic            head_valid, head_read, head_err, rsp_valid, sink_ready;
   logic [2:0]      rsp_op;
   logic [DW-1:0]   rsp_data;
   logic            rsp_err;

   assign head_valid = (count_q != '0);
   assign head_read  = read_mem[rd_ptr_q];
   assign head_err   = err_mem[rd_ptr_q];
   assign rsp_valid  = head_read ? bus.rvalid : bus.bvalid;

   // Only the head's own bus channel is ever made ready, which enforces request order.
   assign bus.bready = head_valid && !head_err && !head_read && sink_ready;
   assign bus.rready = head_valid && !head_err && head_read && sink_ready;
   assign pop        = head_valid && (head_err || rsp_valid) && sink_ready;

   assign rsp_op   = head_read ? OpAccessAckDt : OpAccessAck;
   assign rsp_data = (head_read && !head_err) ? bus.rdata : '0;
   assign rsp_err  = head_err || (head_read ? bus.rresp[1] : bus.bresp[1]);

`ifdef TLUL_AXI_BRIDGE_RSP_REG_EN
   localparam int unsigned RspW = 3 + DW + SrcW + 2 + 1;

   logic            out_v_q, skid_v_q, out_pop;
   logic [RspW-1:0] out_q, skid_q, rsp_bits;

   assign rsp_bits   = {rsp_op, rsp_data, src_mem[rd_ptr_q], size_mem[rd_ptr_q], rsp_err};
   assign sink_ready = !(out_v_q && skid_v_q);
   assign out_pop    = out_v_q && bus.tl_d_ready;

   // Two-slot skid: out_q drives D, skid_q absorbs one beat while D is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         out_v_q  <= 1'b0;
         skid_v_q <= 1'b0;
         out_q    <= '0;
         skid_q   <= '0;
      end else if (out_pop || !out_v_q) begin
         if (skid_v_q) begin
            out_q    <= skid_q;
            out_v_q  <= 1'b1;
            skid_v_q <= pop;
            if (pop) skid_q <= rsp_bits;
         end else if (pop) begin
            out_q   <= rsp_bits;
            out_v_q <= 1'b1;
         end else begin
            out_v_q <= 1'b0;
         end
      end else if (pop) begin
         skid_q   <= rsp_bits;
         skid_v_q <= 1'b1;
      end
   end

   assign bus.tl_d_valid = out_v_q;
   assign {bus.tl_d_opcode, bus.tl_d_data, bus.tl_d_source, bus.tl_d_size,
           bus.tl_d_error} = out_q;
`else
   logic d_valid;

   assign sink_ready     = bus.tl_d_ready;
   assign d_valid        = head_valid && (head_err || rsp_valid);
   assign bus.tl_d_valid = d_valid;
   // Payload held at zero whenever no response is presented
   assign bus.tl_d_opcode = d_valid ? rsp_op : '0;
   assign bus.tl_d_data   = d_valid ? rsp_data : '0;
   assign bus.tl_d_source = d_valid ? src_mem[rd_ptr_q] : '0;
   assign bus.tl_d_size   = d_valid ? size_mem[rd_ptr_q] : '0;
   assign bus.tl_d_error  = d_valid && rsp_err;
`endif

endmodule

// File: tb/tb_tlul_axi_bridge.sv
// Self-checking bench for tlul_axi_bridge (default build, combinational D channel).
module tb_tlul_axi_bridge;

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned SrcW   = 8;
   localparam int unsigned MaxOut = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tlul_axi_bridge_if #(.AW(AW), .DW(DW), .SrcW(SrcW)) bus ();

   tlul_axi_bridge #(
      .AW            (AW),
      .DW            (DW),
      .SrcW          (SrcW),
      .MaxOutstanding(MaxOut)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] data;
      logic [7:0]  src;
      logic [1:0]  size;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [2:0] op, input logic [31:0] data, input logic [7:0] src,
                           input logic [1:0] size, input logic err);
      exp_t e;
      e.op = op; e.data = data; e.src = src; e.size = size; e.err = err;
      exp_q.push_back(e);
   endtask

   // D-channel monitor: a beat seen valid&ready at negedge completes at the next posedge
   always @(negedge clk) begin
      exp_t e_item;
      if (!rst && bus.tl_d_valid && bus.tl_d_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("d_unexpected_beat", 64'(exp_q.size()), 64'd1);
         end else begin
            e_item = exp_q.pop_front();
            check_eq("d_opcode", 64'(bus.tl_d_opcode), 64'(e_item.op));
            check_eq("d_data",   64'(bus.tl_d_data),   64'(e_item.data));
            check_eq("d_source", 64'(bus.tl_d_source), 64'(e_item.src));
            check_eq("d_size",   64'(bus.tl_d_size),   64'(e_item.size));
            check_eq("d_error",  64'(bus.tl_d_error),  64'(e_item.err));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one A beat; returns #1 after the accepting edge
   task automatic tl_send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic [7:0] src, input logic [1:0] size);
      bit got = 1'b0;
      bus.tl_a_valid   = 1'b1;
      bus.tl_a_opcode  = op;
      bus.tl_a_address = addr;
      bus.tl_a_data    = data;
      bus.tl_a_mask    = mask;
      bus.tl_a_source  = src;
      bus.tl_a_size    = size;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = bus.tl_a_ready;
      end
      check_eq("a_accept", 64'(got), 64'd1);
      @(posedge clk);
      #1;
      bus.tl_a_valid = 1'b0;
   endtask

   task automatic axi_r(input logic [31:0] data, input logic [1:0] resp);
      bit got = 1'b0;
      bus.rvalid = 1'b1;
      bus.rdata  = data;
      bus.rresp  = resp;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = bus.rready;
      end
      check_eq("r_accept", 64'(got), 64'd1);
      @(posedge clk);
      #1;
      bus.rvalid = 1'b0;
   endtask

   task automatic axi_b(input logic [1:0] resp);
      bit got = 1'b0;
      bus.bvalid = 1'b1;
      bus.bresp  = resp;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = bus.bready;
      end
      check_eq("b_accept", 64'(got), 64'd1);
      @(posedge clk);
      #1;
      bus.bvalid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc(1);
      check_eq(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.tl_a_valid = 1'b0; bus.tl_a_opcode = '0; bus.tl_a_address = '0; bus.tl_a_data = '0;
      bus.tl_a_mask = '0; bus.tl_a_source = '0; bus.tl_a_size = '0; bus.tl_d_ready = 1'b1;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.bvalid = 1'b0; bus.bresp = '0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;

      // Reset state
      cyc(3);
      check_eq("rst_a_ready", 64'(bus.tl_a_ready), 64'd0);
      check_eq("rst_awvalid", 64'(bus.awvalid), 64'd0);
      check_eq("rst_arvalid", 64'(bus.arvalid), 64'd0);
      check_eq("rst_d_valid", 64'(bus.tl_d_valid), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("idle_a_ready", 64'(bus.tl_a_ready), 64'd1);
      check_eq("idle_wvalid",  64'(bus.wvalid), 64'd0);
      check_eq("idle_bready",  64'(bus.bready), 64'd0);
      check_eq("idle_rready",  64'(bus.rready), 64'd0);
      check_eq("idle_d_data",  64'(bus.tl_d_data), 64'd0);
      check_eq("idle_d_src",   64'(bus.tl_d_source), 64'd0);

      // Single Get
      push_exp(3'd1, 32'hDEADBEEF, 8'h05, 2'd2, 1'b0);
      tl_send(3'd4, 32'h100, 32'h0, 4'hF, 8'h05, 2'd2);
      check_eq("get_arvalid", 64'(bus.arvalid), 64'd1);
      check_eq("get_araddr",  64'(bus.araddr), 64'h100);
      check_eq("get_awvalid", 64'(bus.awvalid), 64'd0);
      check_eq("get_a_ready_blocked", 64'(bus.tl_a_ready), 64'd0);
      bus.arready = 1'b1;
      cyc(1);
      bus.arready = 1'b0;
      check_eq("get_ar_drop", 64'(bus.arvalid), 64'd0);
      axi_r(32'hDEADBEEF, 2'd0);
      drain("drain_get");

      // PutPartial, W before AW, SLVERR response
      push_exp(3'd0, 32'h0, 8'h02, 2'd2, 1'b1);
      tl_send(3'd1, 32'h8, 32'h12345678, 4'h3, 8'h02, 2'd2);
      check_eq("put_awvalid", 64'(bus.awvalid), 64'd1);
      check_eq("put_wvalid",  64'(bus.wvalid), 64'd1);
      check_eq("put_awaddr",  64'(bus.awaddr), 64'h8);
      check_eq("put_wdata",   64'(bus.wdata), 64'h12345678);
      check_eq("put_wstrb",   64'(bus.wstrb), 64'h3);
      bus.wready = 1'b1;
      cyc(1);
      bus.wready = 1'b0;
      check_eq("put_w_drop",  64'(bus.wvalid), 64'd0);
      check_eq("put_aw_held", 64'(bus.awvalid), 64'd1);
      bus.awready = 1'b1;
      cyc(1);
      bus.awready = 1'b0;
      check_eq("put_aw_drop", 64'(bus.awvalid), 64'd0);
      axi_b(2'd2);
      drain("drain_put");

      // Fill the tracker, fifth request must stall, then in-order drain
      bus.arready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         push_exp(3'd1, 32'hA000_0000 | 32'(i), 8'(i), 2'd2, 1'b0);
         tl_send(3'd4, 32'h200 + 32'(i * 4), 32'h0, 4'hF, 8'(i), 2'd2);
      end
      bus.tl_a_valid = 1'b1; bus.tl_a_opcode = 3'd4; bus.tl_a_source = 8'h05;
      cyc(3);
      check_eq("full_a_ready", 64'(bus.tl_a_ready), 64'd0);
      bus.tl_a_valid = 1'b0;
      bus.arready = 1'b0;
      for (int i = 1; i <= 4; i++) axi_r(32'hA000_0000 | 32'(i), 2'd0);
      drain("drain_full");

      // Write then read; R arrives before B and must wait for the write's D beat
      bus.awready = 1'b1; bus.wready = 1'b1; bus.arready = 1'b1;
      push_exp(3'd0, 32'h0, 8'h07, 2'd2, 1'b0);
      tl_send(3'd0, 32'h20, 32'hCAFE, 4'hF, 8'h07, 2'd2);
      push_exp(3'd1, 32'h55AA, 8'h08, 2'd2, 1'b0);
      tl_send(3'd4, 32'h24, 32'h0, 4'hF, 8'h08, 2'd2);
      cyc(2);
      bus.rvalid = 1'b1; bus.rdata = 32'h55AA; bus.rresp = 2'd0;
      #1;
      check_eq("order_rready_wait", 64'(bus.rready), 64'd0);
      check_eq("order_d_wait", 64'(bus.tl_d_valid), 64'd0);
      cyc(2);
      check_eq("order_rready_wait2", 64'(bus.rready), 64'd0);
      bus.bvalid = 1'b1; bus.bresp = 2'd0;
      #1;
      check_eq("order_bready", 64'(bus.bready), 64'd1);
      check_eq("order_rready_b", 64'(bus.rready), 64'd0);
      cyc(1);
      bus.bvalid = 1'b0;
      #1;
      check_eq("order_rready_go", 64'(bus.rready), 64'd1);
      cyc(1);
      bus.rvalid = 1'b0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      drain("drain_order");

      // Local errors: bad opcode, oversize, misaligned
      push_exp(3'd0, 32'h0, 8'h09, 2'd2, 1'b1);
      tl_send(3'd2, 32'h30, 32'h0, 4'hF, 8'h09, 2'd2);
      check_eq("lerr_op_aw", 64'(bus.awvalid), 64'd0);
      check_eq("lerr_op_w",  64'(bus.wvalid), 64'd0);
      push_exp(3'd1, 32'h0, 8'h0A, 2'd3, 1'b1);
      tl_send(3'd4, 32'h40, 32'h0, 4'hF, 8'h0A, 2'd3);
      check_eq("lerr_size_ar", 64'(bus.arvalid), 64'd0);
      push_exp(3'd1, 32'h0, 8'h0B, 2'd2, 1'b1);
      tl_send(3'd4, 32'h42, 32'h0, 4'hF, 8'h0B, 2'd2);
      check_eq("lerr_align_ar", 64'(bus.arvalid), 64'd0);
      drain("drain_lerr");

      // Reset with two reads outstanding drops them; stale responses are not taken
      bus.arready = 1'b1;
      tl_send(3'd4, 32'h50, 32'h0, 4'hF, 8'h0C, 2'd2);
      tl_send(3'd4, 32'h54, 32'h0, 4'hF, 8'h0D, 2'd2);
      cyc(2);
      bus.arready = 1'b0;
      rst = 1'b1;
      cyc(1);
      check_eq("mrst_arvalid", 64'(bus.arvalid), 64'd0);
      check_eq("mrst_d_valid", 64'(bus.tl_d_valid), 64'd0);
      check_eq("mrst_a_ready", 64'(bus.tl_a_ready), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      bus.rvalid = 1'b1; bus.rdata = 32'hBAD; bus.bvalid = 1'b1;
      #1;
      check_eq("stale_rready", 64'(bus.rready), 64'd0);
      check_eq("stale_bready", 64'(bus.bready), 64'd0);
      check_eq("stale_d_valid", 64'(bus.tl_d_valid), 64'd0);
      check_eq("post_rst_a_ready", 64'(bus.tl_a_ready), 64'd1);
      cyc(2);
      check_eq("stale_rready2", 64'(bus.rready), 64'd0);
      bus.rvalid = 1'b0; bus.bvalid = 1'b0;

      // Recovery transaction after reset
      bus.arready = 1'b1;
      push_exp(3'd1, 32'h77, 8'h0E, 2'd2, 1'b0);
      tl_send(3'd4, 32'h60, 32'h0, 4'hF, 8'h0E, 2'd2);
      axi_r(32'h77, 2'd0);
      bus.arready = 1'b0;
      drain("drain_recover");

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
